// File: rtl/lzc_pipe.sv
// lzc_pipe: two-stage pipelined leading-zero counter with valid/ready on both
// sides. Stage 1 counts leading zeros of each operand half; stage 2 merges the
// halves into the final count. Optional left-normaliser built when LZC_NORM_EN
// is defined; otherwise out_norm is tied to zero and the data path is not built.
module lzc_pipe #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CW-1:0]    out_lzc,
   output logic             out_zero,
   output logic [WIDTH-1:0] out_norm,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int H  = WIDTH / 2;
   localparam int HW = $clog2(H) + 1;

   // Leading zeros of one half, MSB-first; an all-zero half yields H.
   function automatic logic [HW-1:0] lzc_half(input logic [H-1:0] v);
      logic [HW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = H - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + HW'(1);
         end
      end
      return n;
   endfunction

   // pipeline state
   logic          v1_q, v2_q;
   logic [HW-1:0] hi_lzc_q, lo_lzc_q;
   logic          hi_zero_q, lo_zero_q;
   logic [CW-1:0] lzc_q;
   logic          zero_q;

   // stage inputs
   logic [HW-1:0] hi_lzc_d, lo_lzc_d;
   logic          hi_zero_d, lo_zero_d;
   logic [CW-1:0] lzc_d;
   logic          zero_d;
   logic          adv1, adv2;

   // A stage may advance when it is empty or its successor is advancing.
   assign adv2     = ~v2_q | out_ready;
   assign adv1     = ~v1_q | adv2;
   assign in_ready = adv1;

   // Stage-1 half counts computed from the incoming operand.
   always_comb begin
      hi_lzc_d  = lzc_half(in_data[WIDTH-1:H]);
      lo_lzc_d  = lzc_half(in_data[H-1:0]);
      hi_zero_d = ~|in_data[WIDTH-1:H];
      lo_zero_d = ~|in_data[H-1:0];
   end

   // Merge halves: a zero upper half defers to the lower half's count.
   always_comb begin
      lzc_d  = hi_zero_q ? (CW'(H) + CW'(lo_lzc_q)) : CW'(hi_lzc_q);
      zero_d = hi_zero_q & lo_zero_q;
   end

   // Stage 1 registers: load on input transfer, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q      <= 1'b0;
         hi_lzc_q  <= '0;
         lo_lzc_q  <= '0;
         hi_zero_q <= 1'b0;
         lo_zero_q <= 1'b0;
      end else begin
         if (adv1) v1_q <= in_valid;
         if (adv1 && in_valid) begin
            hi_lzc_q  <= hi_lzc_d;
            lo_lzc_q  <= lo_lzc_d;
            hi_zero_q <= hi_zero_d;
            lo_zero_q <= lo_zero_d;
         end
      end
   end

   // Stage 2 registers drive the outputs; they hold while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q   <= 1'b0;
         lzc_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         if (adv2) v2_q <= v1_q;
         if (adv2 && v1_q) begin
            lzc_q  <= lzc_d;
            zero_q <= zero_d;
         end
      end
   end

   assign out_valid = v2_q;
   assign out_lzc   = lzc_q;
   assign out_zero  = zero_q;

`ifdef LZC_NORM_EN
   logic [WIDTH-1:0] data1_q;
   logic [WIDTH-1:0] norm_q;
   logic [WIDTH-1:0] norm_d;

   // Logical left shift by the final count; a count of WIDTH clears the word.
   assign norm_d = data1_q << lzc_d;

   // Operand copy travelling alongside the stage-1 counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    data1_q <= '0;
      else if (adv1 && in_valid)  data1_q <= in_data;
   end

   // Normalised operand registered with the stage-2 results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 norm_q <= '0;
      else if (adv2 && v1_q)   norm_q <= norm_d;
   end

   assign out_norm = norm_q;
`else
   assign out_norm = '0;
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// Bench for lzc_pipe: scoreboard against an arithmetic reference, directed
// values, back-to-back streaming, stall/drain, randomized traffic, mid-stream
// asynchronous reset, and a 32-bit instance. Normaliser checks follow LZC_NORM_EN.
module tb_lzc_pipe;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [CW-1:0]    out_lzc;
   logic             out_zero;
   logic [WIDTH-1:0] out_norm;
   logic             out_valid;
   logic             out_ready = 1'b1;

   logic [31:0]      in32_data = '0;
   logic             in32_valid = 1'b0;
   logic             in32_ready;
   logic [5:0]       out32_lzc;
   logic             out32_zero;
   logic [31:0]      out32_norm;
   logic             out32_valid;
   logic             out32_ready = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_cnt = 0;
   int out_cnt = 0;

   logic [WIDTH-1:0] ref_q[$];

   lzc_pipe #(.WIDTH(WIDTH)) u_dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_lzc(out_lzc), .out_zero(out_zero), .out_norm(out_norm),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   lzc_pipe #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst),
      .in_data(in32_data), .in_valid(in32_valid), .in_ready(in32_ready),
      .out_lzc(out32_lzc), .out_zero(out32_zero), .out_norm(out32_norm),
      .out_valid(out32_valid), .out_ready(out32_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: leading zeros = WIDTH minus the operand's bit length.
   function automatic int ref_lzc(input logic [WIDTH-1:0] v);
      longint unsigned x;
      x = longint'(v);
      if (x == 0) return WIDTH;
      return WIDTH - $clog2(x + 1);
   endfunction

   function automatic logic [WIDTH-1:0] ref_norm(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
`ifdef LZC_NORM_EN
      r = v << ref_lzc(v);
`else
      r = '0;
`endif
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] rand_data();
      logic [WIDTH-1:0] r;
      r = WIDTH'($urandom);
      if ($urandom_range(0, 4) == 0) r = '0;
      else r = r >> $urandom_range(0, WIDTH - 1);
      return r;
   endfunction

   // Scoreboard monitor: sampled on the falling edge, ahead of the next transfer.
   initial begin
      logic             hold_pending;
      logic [CW-1:0]    hold_lzc;
      logic [WIDTH-1:0] v;
      hold_pending = 1'b0;
      hold_lzc     = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               check("hold_valid", 64'(out_valid), 64'd1);
               check("hold_lzc", 64'(out_lzc), 64'(hold_lzc));
            end
            if (out_valid && out_ready) begin
               check("sb_has_entry", 64'(ref_q.size() > 0), 64'd1);
               if (ref_q.size() > 0) begin
                  v = ref_q.pop_front();
                  check("sb_lzc", 64'(out_lzc), 64'(ref_lzc(v)));
                  check("sb_zero", 64'(out_zero), 64'(v == '0));
                  check("sb_norm", 64'(out_norm), 64'(ref_norm(v)));
                  $display("[TB] out op=%h lzc=%0d zero=%0d norm=%h", v, out_lzc, out_zero, out_norm);
               end
               out_cnt++;
            end
            hold_pending = out_valid && !out_ready;
            hold_lzc     = out_lzc;
            if (in_valid && in_ready) begin
               ref_q.push_back(in_data);
               acc_cnt++;
            end
         end
      end
   end

   task automatic send_one(input logic [WIDTH-1:0] v, input int exp_lzc, input logic exp_zero);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_s1_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_s2_valid", 64'(out_valid), 64'd1);
      check("dir_lzc", 64'(out_lzc), 64'(exp_lzc));
      check("dir_zero", 64'(out_zero), 64'(exp_zero));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [WIDTH-1:0] dir_val [5];
      int               dir_lzc [5];
      int               first, last, cnt, acc0, out0;
      logic [CW-1:0]    stall_lzc;
      dir_val = '{8'h80, 8'h01, 8'h00, 8'h10, 8'hFF};
      dir_lzc = '{0, 7, 8, 3, 0};
      stall_lzc = '0;

      // Power-on reset, checked while still asserted.
      #1 rst = 1'b1;
      #10;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_lzc", 64'(out_lzc), 64'd0);
      check("rst_out_zero", 64'(out_zero), 64'd0);
      check("rst_out_norm", 64'(out_norm), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      #12 rst = 1'b0;
      idle(2);

      // Directed values with latency checks.
      for (int i = 0; i < 5; i++) begin
         $display("[TB] directed op=%h", dir_val[i]);
         send_one(dir_val[i], dir_lzc[i], dir_val[i] == '0);
      end
`ifdef LZC_NORM_EN
      send_one(8'h13, 3, 1'b0);
      check("norm_13", 64'(out_norm), 64'h98);
      send_one(8'h00, 8, 1'b1);
      check("norm_00", 64'(out_norm), 64'h00);
`endif
      idle(2);

      // Back-to-back stream of 10: results must appear on consecutive cycles.
      first = -1; last = -1; cnt = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               @(posedge clk); #1;
               in_valid = 1'b1;
               in_data  = rand_data();
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 16; i++) begin
               @(negedge clk);
               if (out_valid) begin
                  cnt++;
                  if (first < 0) first = i;
                  last = i;
               end
            end
         end
      join
      check("b2b_count", 64'(cnt), 64'd10);
      check("b2b_contiguous", 64'(last - first), 64'd9);

      // Stall: exactly two operands buffered, outputs frozen, then drained.
      idle(3);
      acc0 = acc_cnt;
      out0 = out_cnt;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = rand_data();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) stall_lzc = out_lzc;
         if (i >= 2) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_lzc", 64'(out_lzc), 64'(stall_lzc));
         end
         @(posedge clk); #1;
         in_data = rand_data();
      end
      check("stall_accepted", 64'(acc_cnt - acc0), 64'd2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(4);
      check("stall_drained", 64'(out_cnt - out0), 64'd2);

      // Randomized traffic on both handshakes.
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = rand_data();
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(4);
      check("rand_sb_empty", 64'(ref_q.size()), 64'd0);
      check("rand_in_out", 64'(out_cnt), 64'(acc_cnt));

      // Asynchronous reset mid-stream with the pipeline full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = WIDTH'(1);
      idle(3);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_lzc", 64'(out_lzc), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      ref_q.delete();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #3;
      rst = 1'b0;
      acc_cnt = 0;
      out_cnt = 0;
      idle(2);
      check("post_rst_idle", 64'(out_valid), 64'd0);
      send_one(8'h20, 2, 1'b0);
      idle(2);
      check("post_rst_count", 64'(out_cnt), 64'd1);

      // 32-bit instance: count spans the half boundary and reaches WIDTH.
      @(posedge clk); #1;
      in32_valid = 1'b1;
      in32_data  = 32'h0000_8000;
      @(posedge clk); #1;
      in32_data  = 32'h0;
      @(posedge clk); #1;
      in32_valid = 1'b0;
      check("w32_valid_a", 64'(out32_valid), 64'd1);
      check("w32_lzc_8000", 64'(out32_lzc), 64'd16);
      @(posedge clk); #1;
      check("w32_valid_b", 64'(out32_valid), 64'd1);
      check("w32_lzc_0", 64'(out32_lzc), 64'd32);
      check("w32_zero_0", 64'(out32_zero), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
